// File: rtl/stream_stats_pkg.sv
// Shared types for the stream min/max statistics block: controller states and sample width.
package stream_stats_pkg;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        ACCEPT,
        CMP_MAX,
        CMP_MIN,
        DONE
    } state_t;
endpackage

// File: rtl/mag_cmp8.sv
// Combinational unsigned magnitude comparator; zero latency, exactly one of eq/gt/lt is high.
module mag_cmp8
    import stream_stats_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_eq,
    output logic              o_gt,
    output logic              o_lt
);
    assign o_eq = (i_a == i_b);
    assign o_gt = (i_a >  i_b);
    assign o_lt = (i_a <  i_b);
endmodule

// File: rtl/stream_minmax_ctrl.sv
// Frame min/max/count over a byte stream using one shared comparator; 3 cycles per sample after the first.
// Result held in DONE until out_ready; in_ready is decoded from state alone and drops during compares.
module stream_minmax_ctrl
    import stream_stats_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  min_val,
    output logic [DATA_W-1:0]  max_val,
    output logic [COUNT_W-1:0] count,
    output logic               count_sat,
    output logic               busy
);
    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_min;
    logic [DATA_W-1:0]   r_max;
    logic [DATA_W-1:0]   r_hold;
    logic                r_last;
    logic [COUNT_W-1:0]  r_count;
    logic                r_sat;
    logic [DATA_W-1:0]   w_cmp_b;
    logic                w_eq;
    logic                w_gt;
    logic                w_lt;
    logic                w_hs;

    // Operand b follows the compare pass; a is always the held sample.
    assign w_cmp_b = (r_state == CMP_MIN) ? r_min : r_max;

    mag_cmp8 u_cmp (
        .i_a  (r_hold),
        .i_b  (w_cmp_b),
        .o_eq (w_eq),
        .o_gt (w_gt),
        .o_lt (w_lt)
    );

    assign in_ready  = (r_state == FIRST) || (r_state == ACCEPT);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign w_hs      = in_valid && in_ready;

    assign min_val   = r_min;
    assign max_val   = r_max;
    assign count     = r_count;
    assign count_sat = r_sat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = FIRST;
            FIRST:   if (w_hs) w_next = in_last ? DONE : ACCEPT;
            ACCEPT:  if (w_hs) w_next = CMP_MAX;
            CMP_MAX: w_next = CMP_MIN;
            CMP_MIN: w_next = r_last ? DONE : ACCEPT;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_min   <= '0;
            r_max   <= '0;
            r_hold  <= '0;
            r_last  <= 1'b0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            case (r_state)
                FIRST: begin
                    if (w_hs) begin
                        r_min   <= in_data;
                        r_max   <= in_data;
                        r_count <= COUNT_W'(1);
                        r_sat   <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (w_hs) begin
                        r_hold <= in_data;
                        r_last <= in_last;
                    end
                end
                CMP_MAX: begin
                    if (w_gt) r_max <= r_hold;
                end
                CMP_MIN: begin
                    if (w_lt) r_min <= r_hold;
                    // The sample is counted once both passes are done; the counter sticks at all-ones.
                    if (&r_count) r_sat <= 1'b1;
                    else          r_count <= r_count + COUNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    a_cmp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot({w_eq, w_gt, w_lt}));
endmodule
